// File: rtl/alu_seq_pkg.sv
// Shared constants for the accumulator-ALU sequencer: opcodes, FSM state codes,
// datapath Sel codes and jump-condition kinds.
package alu_seq_pkg;

    localparam logic [3:0] OP_ALU_MAX = 4'b0100;
    localparam logic [3:0] OP_OUT     = 4'b0101;
    localparam logic [3:0] OP_JMP     = 4'b1000;
    localparam logic [3:0] OP_JC      = 4'b1001;
    localparam logic [3:0] OP_JZ      = 4'b1010;
    localparam logic [3:0] OP_HALT    = 4'b1111;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_DECODE  = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_HALT    = 3'd4;

    localparam logic [2:0] SEL_OP0    = 3'b000;
    localparam logic [2:0] SEL_OP1    = 3'b001;
    localparam logic [2:0] SEL_OP2    = 3'b010;
    localparam logic [2:0] SEL_OP3    = 3'b011;
    localparam logic [2:0] SEL_OP4    = 3'b100;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'd0,
        COND_C      = 2'd1,
        COND_Z      = 2'd2
    } cond_e;

    // ALU opcodes map one-to-one onto the datapath's Sel codes.
    function automatic logic [2:0] alu_sel(input logic [3:0] op);
        logic [2:0] sel;
        case (op)
            4'b0000: sel = SEL_OP0;
            4'b0001: sel = SEL_OP1;
            4'b0010: sel = SEL_OP2;
            4'b0011: sel = SEL_OP3;
            4'b0100: sel = SEL_OP4;
            default: sel = SEL_OP0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction decoder: opcode/operand -> datapath controls and
// jump classification.
module alu_seq_decode
    import alu_seq_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W+3:0] i_ir,
    output logic [2:0]      o_sel,
    output logic [3:0]      o_in_bus1,
    output logic            o_bus1_en,
    output logic            o_bus2_en,
    output logic            o_is_alu,
    output logic            o_is_jump,
    output cond_e           o_cond
);

    logic [OP_W-1:0] w_op;
    assign w_op = i_ir[OP_W+3:4];

    always_comb begin
        o_sel     = alu_sel(4'(w_op));
        o_in_bus1 = i_ir[3:0];
        o_bus1_en = 1'b0;
        o_bus2_en = 1'b0;
        o_is_alu  = 1'b0;
        o_is_jump = 1'b0;
        o_cond    = COND_ALWAYS;
        if (w_op <= OP_W'(OP_ALU_MAX)) begin
            o_is_alu  = 1'b1;
            o_bus1_en = 1'b1;
            o_bus2_en = 1'b1;
        end else begin
            case (w_op)
                OP_W'(OP_OUT): o_bus2_en = 1'b1;
                OP_W'(OP_JMP): o_is_jump = 1'b1;
                OP_W'(OP_JC): begin
                    o_is_jump = 1'b1;
                    o_cond    = COND_C;
                end
                OP_W'(OP_JZ): begin
                    o_is_jump = 1'b1;
                    o_cond    = COND_Z;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute controller driving the 4-bit accumulator ALU datapath.
//   state  | meaning
//   IDLE   | waiting for run
//   FETCH  | latch instruction at pc into ir
//   DECODE | load Sel/in_bus1/bus enables from ir, arm accu_en for ALU ops
//   EXEC   | accu_en pulse, flag latch, pc update
//   HALT   | frozen until reset
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int PC_W = 4,
    parameter int OP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [OP_W+3:0]   prog_data,
    input  logic              c,
    input  logic              z,
    output logic [PC_W-1:0]   pc,
    output logic [2:0]        Sel,
    output logic [3:0]        in_bus1,
    output logic              accu_en,
    output logic              bus1_en,
    output logic              bus2_en,
    output logic              halted
);

    logic [2:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic [OP_W+3:0] r_ir;
    logic [2:0]      r_sel;
    logic [3:0]      r_in_bus1;
    logic            r_accu_en;
    logic            r_bus1_en;
    logic            r_bus2_en;
    logic            r_halted;
    logic            r_c_q;
    logic            r_z_q;

    logic [2:0]      w_sel;
    logic [3:0]      w_in_bus1;
    logic            w_bus1_en;
    logic            w_bus2_en;
    logic            w_is_alu;
    logic            w_is_jump;
    cond_e           w_cond;
    logic            w_is_halt;
    logic            w_take;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pc_inc;

    alu_seq_decode #(.OP_W(OP_W)) u_decode (
        .i_ir      (r_ir),
        .o_sel     (w_sel),
        .o_in_bus1 (w_in_bus1),
        .o_bus1_en (w_bus1_en),
        .o_bus2_en (w_bus2_en),
        .o_is_alu  (w_is_alu),
        .o_is_jump (w_is_jump),
        .o_cond    (w_cond)
    );

    assign w_is_halt = (r_ir[OP_W+3:4] == OP_W'(OP_HALT));
    assign w_target  = PC_W'(r_ir[3:0]);
    assign w_pc_inc  = r_pc + PC_W'(1);

    // Conditions use flags captured by the last ALU op, never the live c/z.
    always_comb begin
        w_take = 1'b0;
        if (w_is_jump) begin
            case (w_cond)
                COND_C:  w_take = r_c_q;
                COND_Z:  w_take = r_z_q;
                default: w_take = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_sel     <= 3'b000;
            r_in_bus1 <= 4'h0;
            r_accu_en <= 1'b0;
            r_bus1_en <= 1'b0;
            r_bus2_en <= 1'b0;
            r_halted  <= 1'b0;
            r_c_q     <= 1'b0;
            r_z_q     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run) r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    r_ir    <= prog_data;
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    // Sel/in_bus1 only change on ALU ops; everything else holds them.
                    if (w_is_alu) begin
                        r_sel     <= w_sel;
                        r_in_bus1 <= w_in_bus1;
                    end
                    r_bus1_en <= w_bus1_en;
                    r_bus2_en <= w_bus2_en;
                    r_accu_en <= w_is_alu;
                    r_state   <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_accu_en <= 1'b0;
                    if (w_is_alu) begin
                        r_c_q <= c;
                        r_z_q <= z;
                    end
                    if (w_is_halt) begin
                        r_halted <= 1'b1;
                        r_state  <= ST_HALT;
                    end else begin
                        r_pc    <= w_take ? w_target : w_pc_inc;
                        r_state <= ST_FETCH;
                    end
                end
                ST_HALT: ;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pc      = r_pc;
    assign Sel     = r_sel;
    assign in_bus1 = r_in_bus1;
    assign accu_en = r_accu_en;
    assign bus1_en = r_bus1_en;
    assign bus2_en = r_bus2_en;
    assign halted  = r_halted;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: an instruction-level interpreter predicts
// the datapath controls seen in every EXEC cycle and the HALT state.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic [7:0] prog_data;
    logic       c;
    logic       z;
    logic [3:0] pc;
    logic [2:0] Sel;
    logic [3:0] in_bus1;
    logic       accu_en;
    logic       bus1_en;
    logic       bus2_en;
    logic       halted;

    logic [7:0]  mem [16];
    logic [15:0] c_tab = '0;
    logic [15:0] z_tab = '0;
    bit          active = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        int         n;
        logic [3:0] pc;
        logic [2:0] sel;
        logic [3:0] inb;
        logic       b1;
        logic       b2;
        logic       acc;
        logic       hlt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    alu_sequencer #(.PC_W(4), .OP_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .prog_data (prog_data),
        .c         (c),
        .z         (z),
        .pc        (pc),
        .Sel       (Sel),
        .in_bus1   (in_bus1),
        .accu_en   (accu_en),
        .bus1_en   (bus1_en),
        .bus2_en   (bus2_en),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Datapath flags are a function of the instruction address being executed.
    assign prog_data = mem[pc];
    assign c = active ? c_tab[pc] : 1'b0;
    assign z = active ? z_tab[pc] : 1'b0;

    always @(posedge clk) begin
        if (active) cyc <= cyc + 1;
        else        cyc <= 0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    task automatic push(input int n, input logic [3:0] p, input logic [2:0] s, input logic [3:0] inb,
                        input logic b1, input logic b2, input logic acc, input logic hlt);
        exp_t e;
        e.n = n; e.pc = p; e.sel = s; e.inb = inb;
        e.b1 = b1; e.b2 = b2; e.acc = acc; e.hlt = hlt;
        exp_q.push_back(e);
    endtask

    // Instruction-level interpreter; instruction k executes in cycle 3k+3 after run is taken.
    task automatic build_model(input int max_instr, output int last_n);
        logic [3:0] p, op, opd, inb;
        logic [2:0] s;
        logic       cq, zq;
        logic [7:0] ins;
        p = 4'd0; s = 3'd0; inb = 4'd0; cq = 1'b0; zq = 1'b0; last_n = 0;
        exp_q.delete();
        for (int k = 0; k < max_instr; k++) begin
            ins = mem[p];
            op  = ins[7:4];
            opd = ins[3:0];
            if (op <= 4'd4) begin
                s = op[2:0];
                inb = opd;
                push(3*k+3, p, s, inb, 1'b1, 1'b1, 1'b1, 1'b0);
                cq = c_tab[p];
                zq = z_tab[p];
                p = p + 4'd1;
            end else if (op == 4'h5) begin
                push(3*k+3, p, s, inb, 1'b0, 1'b1, 1'b0, 1'b0);
                p = p + 4'd1;
            end else if (op == 4'hF) begin
                push(3*k+3, p, s, inb, 1'b0, 1'b0, 1'b0, 1'b0);
                push(3*k+4, p, s, inb, 1'b0, 1'b0, 1'b0, 1'b1);
                push(3*k+6, p, s, inb, 1'b0, 1'b0, 1'b0, 1'b1);
                last_n = 3*k+6;
                return;
            end else begin
                push(3*k+3, p, s, inb, 1'b0, 1'b0, 1'b0, 1'b0);
                case (op)
                    4'h8:    p = opd;
                    4'h9:    p = cq ? opd : p + 4'd1;
                    4'hA:    p = zq ? opd : p + 4'd1;
                    default: p = p + 4'd1;
                endcase
            end
            last_n = 3*k+3;
        end
    endtask

    always @(negedge clk) begin
        if (active && reset) begin
            if (exp_q.size() > 0 && exp_q[0].n == cyc) begin
                mon_e = exp_q.pop_front();
                check("pc",      32'(pc),      32'(mon_e.pc));
                check("Sel",     32'(Sel),     32'(mon_e.sel));
                check("in_bus1", 32'(in_bus1), 32'(mon_e.inb));
                check("bus1_en", 32'(bus1_en), 32'(mon_e.b1));
                check("bus2_en", 32'(bus2_en), 32'(mon_e.b2));
                check("accu_en", 32'(accu_en), 32'(mon_e.acc));
                check("halted",  32'(halted),  32'(mon_e.hlt));
            end else begin
                check("accu_en_outside_exec", 32'(accu_en), 32'd0);
            end
        end
    end

    task automatic clear_mem();
        for (int a = 0; a < 16; a++) mem[a] = 8'hF0;
        c_tab = '0;
        z_tab = '0;
    endtask

    // Called at a falling edge; reset lands mid-cycle.
    task automatic do_reset();
        #2;
        reset  = 1'b0;
        active = 1'b0;
        run    = 1'b0;
        #1;
        check("rst_pc",      32'(pc),      32'd0);
        check("rst_accu_en", 32'(accu_en), 32'd0);
        check("rst_bus1_en", 32'(bus1_en), 32'd0);
        check("rst_bus2_en", 32'(bus2_en), 32'd0);
        check("rst_Sel",     32'(Sel),     32'd0);
        check("rst_in_bus1", 32'(in_bus1), 32'd0);
        check("rst_halted",  32'(halted),  32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_program(input int max_instr);
        int last;
        build_model(max_instr, last);
        @(negedge clk);
        run    = 1'b1;
        active = 1'b1;
        for (int i = 0; i < last + 2; i++) begin
            @(negedge clk);
            run = 1'($urandom);
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        do_reset();
    endtask

    initial begin
        int last;
        logic [3:0] op;
        int r;
        logic [3:0] misc_ops [7];
        misc_ops = '{4'h6, 4'h7, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

        clear_mem();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_pc",      32'(pc),      32'd0);
        check("idle_accu_en", 32'(accu_en), 32'd0);
        check("idle_bus1_en", 32'(bus1_en), 32'd0);
        check("idle_bus2_en", 32'(bus2_en), 32'd0);
        check("idle_halted",  32'(halted),  32'd0);

        // Three ALU ops then HALT at address 3.
        clear_mem();
        mem[0] = 8'h31; mem[1] = 8'h17; mem[2] = 8'h05; mem[3] = 8'hF0;
        run_program(20);

        // JC taken / not taken, JZ taken.
        clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h9A; c_tab[0] = 1'b1;
        run_program(20);
        clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h9A; c_tab[1] = 1'b1;
        run_program(20);
        clear_mem();
        mem[0] = 8'h2C; mem[1] = 8'hA6; z_tab[0] = 1'b1;
        run_program(20);

        // OUT between the ALU op and JZ must not disturb the latched zero flag.
        clear_mem();
        mem[0] = 8'h23; mem[1] = 8'h50; mem[2] = 8'hA6; z_tab[0] = 1'b1;
        run_program(20);

        // JMP to 15, NOP at 15 wraps to 0, then JC is taken the second time round.
        clear_mem();
        mem[0] = 8'h93; mem[1] = 8'h01; mem[2] = 8'h8F; mem[15] = 8'hE0; c_tab[1] = 1'b1;
        run_program(20);

        // Reset during the EXEC of the ALU op at address 1, after a carry was latched.
        clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h31; c_tab[0] = 1'b1; c_tab[1] = 1'b1;
        build_model(20, last);
        @(negedge clk);
        run    = 1'b1;
        active = 1'b1;
        repeat (6) begin
            @(negedge clk);
            run = 1'b0;
        end
        check("pre_reset_accu_en", 32'(accu_en), 32'd1);
        check("pre_reset_pc",      32'(pc),      32'd1);
        do_reset();
        // Restart from 0: JC must fall through because the carry flag was cleared.
        mem[0] = 8'h95; mem[1] = 8'hF0; mem[5] = 8'hF0;
        run_program(10);

        for (int t = 0; t < 12; t++) begin
            clear_mem();
            for (int a = 0; a < 16; a++) begin
                r = int'($urandom_range(0, 9));
                if (r < 5)       op = 4'($urandom_range(0, 4));
                else if (r == 5) op = 4'h5;
                else if (r == 6) op = 4'h8;
                else if (r == 7) op = 4'h9;
                else if (r == 8) op = 4'hA;
                else             op = misc_ops[$urandom_range(0, 6)];
                mem[a] = {op, 4'($urandom)};
            end
            c_tab = 16'($urandom);
            z_tab = 16'($urandom);
            run_program(30);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
